// File: rtl/iter_shift_pkg.sv
// Shared operation codes and FSM state encoding for the iterative shifter.
package iter_shift_pkg;

    localparam logic [1:0] OP_SRL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/iter_shift_unit_step.sv
// Combinational one-position shifter: per-bit neighbour select plus an MSB fill
// that supplies zero, the sign bit, or the wrapped LSB depending on the operation.
module shift_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] d,
    input  logic [1:0]   op,
    output logic [N-1:0] q
);
    import iter_shift_pkg::*;

    logic msb_fill;

    always_comb begin
        msb_fill = 1'b0;
        case (op)
            OP_SRA:  msb_fill = d[N-1];
            OP_ROR:  msb_fill = d[0];
            default: msb_fill = 1'b0;
        endcase
    end

    // Left shift pulls from the lower neighbour; every right-type op pulls from the upper one.
    for (genvar i = 0; i < N; i++) begin : g_bit
        if (i == N-1) begin : g_msb
            assign q[i] = (op == OP_SLL) ? d[i-1] : msb_fill;
        end else if (i == 0) begin : g_lsb
            assign q[i] = (op == OP_SLL) ? 1'b0 : d[i+1];
        end else begin : g_mid
            assign q[i] = (op == OP_SLL) ? d[i-1] : d[i+1];
        end
    end

endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shifter: moves the operand one bit per clock under a small
// IDLE/SHIFT/DONE controller with a start/busy/done handshake.
module iter_shift_unit #(
    parameter  int N  = 8,
    localparam int SW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    op,
    input  logic [SW-1:0] shamt,
    input  logic [N-1:0]  a,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result
);
    import iter_shift_pkg::*;

    state_e        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  data_q, data_d;
    logic [1:0]    op_q, op_d;
    logic [N-1:0]  result_q, result_d;
    logic [N-1:0]  step_data;

    shift_step #(.N(N)) u_step (
        .d  (data_q),
        .op (op_q),
        .q  (step_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            op_q     <= OP_SRL;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            op_q     <= op_d;
            result_q <= result_d;
        end
    end

    // The count reaching zero means the data register already holds the final value.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        op_d     = op_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    data_d  = a;
                    cnt_d   = shamt;
                    op_d    = op;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    result_d = data_q;
                    state_d  = S_DONE;
                end else begin
                    data_d = step_data;
                    cnt_d  = cnt_q - SW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// Directed and randomised checks of iter_shift_unit at N=8 and N=5, run side by side.
module tb_iter_shift_unit;

    typedef struct {
        logic [1:0] op;
        logic [7:0] a;
        logic [2:0] shamt;
        logic [7:0] exp;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [1:0] op;
    logic [7:0] a;
    logic [2:0] shamt;
    logic       busy8, done8, busy5, done5;
    logic [7:0] result8;
    logic [4:0] result5;

    int n_cmp  = 0;
    int n_fail = 0;

    vec_t vecs[12];

    iter_shift_unit #(.N(8)) dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .shamt  (shamt),
        .a      (a),
        .busy   (busy8),
        .done   (done8),
        .result (result8)
    );

    iter_shift_unit #(.N(5)) dut5 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .shamt  (shamt),
        .a      (a[4:0]),
        .busy   (busy5),
        .done   (done5),
        .result (result5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    // Bit-serial reference for an n-bit operand held in the low bits of an 8-bit value.
    function automatic logic [7:0] ref_shift(input logic [1:0] op_i, input logic [7:0] a_i,
                                             input int sh, input int n);
        logic [7:0] d, mask;
        logic       fill;
        mask = 8'((1 << n) - 1);
        d    = a_i & mask;
        for (int k = 0; k < sh; k++) begin
            case (op_i)
                2'b00: d = d >> 1;
                2'b01: d = (d << 1) & mask;
                2'b10: begin fill = d[n-1]; d = (d >> 1) | (8'(fill) << (n-1)); end
                default: begin fill = d[0]; d = (d >> 1) | (8'(fill) << (n-1)); end
            endcase
        end
        return d;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(inout int lat, output int nbusy);
        nbusy = 0;
        while (1) begin
            if (busy8) nbusy++;
            if (done8 || lat >= 40) break;
            @(negedge clk);
            lat++;
        end
        check_output("done_seen", {31'd0, done8}, 32'd1);
    endtask

    task automatic apply_stimulus(input logic [1:0] op_i, input logic [7:0] a_i, input logic [2:0] sh_i,
                                  output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1;
        op    = op_i;
        a     = a_i;
        shamt = sh_i;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        wait_done(lat, nbusy);
    endtask

    initial begin
        int         lat, nbusy, pulses;
        logic [1:0] rop;
        logic [7:0] ra;
        logic [2:0] rsh;

        vecs[0]  = '{2'b00, 8'hB4, 3'd3, 8'h16};
        vecs[1]  = '{2'b10, 8'hB4, 3'd2, 8'hED};
        vecs[2]  = '{2'b01, 8'h81, 3'd1, 8'h02};
        vecs[3]  = '{2'b11, 8'h81, 3'd1, 8'hC0};
        vecs[4]  = '{2'b11, 8'h81, 3'd7, 8'h03};
        vecs[5]  = '{2'b01, 8'h5A, 3'd0, 8'h5A};
        vecs[6]  = '{2'b00, 8'h80, 3'd7, 8'h01};
        vecs[7]  = '{2'b10, 8'h80, 3'd7, 8'hFF};
        vecs[8]  = '{2'b01, 8'h01, 3'd7, 8'h80};
        vecs[9]  = '{2'b11, 8'h0F, 3'd4, 8'hF0};
        vecs[10] = '{2'b10, 8'h7F, 3'd3, 8'h0F};
        vecs[11] = '{2'b00, 8'hFF, 3'd0, 8'hFF};

        rst_n = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        a     = 8'h00;
        shamt = 3'd0;
        repeat (3) @(negedge clk);
        check_output("reset_busy8",   {31'd0, busy8}, 32'd0);
        check_output("reset_done8",   {31'd0, done8}, 32'd0);
        check_output("reset_result8", {24'd0, result8}, 32'd0);
        check_output("reset_busy5",   {31'd0, busy5}, 32'd0);
        check_output("reset_result5", {27'd0, result5}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].shamt, lat, nbusy);
            check_output($sformatf("vec%0d_result", i), {24'd0, result8}, {24'd0, vecs[i].exp});
            check_output($sformatf("vec%0d_latency", i), lat, vecs[i].shamt + 2);
            check_output($sformatf("vec%0d_busy_cycles", i), nbusy, vecs[i].shamt + 2);
            check_output($sformatf("vec%0d_done5", i), {31'd0, done5}, 32'd1);
            check_output($sformatf("vec%0d_result5", i), {27'd0, result5},
                         {24'd0, ref_shift(vecs[i].op, vecs[i].a, vecs[i].shamt, 5)});
            @(negedge clk);
            check_output($sformatf("vec%0d_done_drop", i), {31'd0, done8}, 32'd0);
            check_output($sformatf("vec%0d_idle", i), {31'd0, busy8}, 32'd0);
        end

        // A start while shifting must not disturb the operation in flight.
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 8'hFF; shamt = 3'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 8'h00; shamt = 3'd1;
        @(negedge clk);
        start = 1'b0;
        lat   = 3;
        wait_done(lat, nbusy);
        check_output("busy_start_result", {24'd0, result8}, 32'h01);
        check_output("busy_start_latency", lat, 9);

        // Start raised during DONE is ignored; held into IDLE it is accepted.
        start = 1'b1; op = 2'b00; a = 8'hAA; shamt = 3'd0;
        @(negedge clk);
        check_output("done_start_ignored", {31'd0, busy8}, 32'd0);
        check_output("done_pulse_single", {31'd0, done8}, 32'd0);
        op = 2'b01; a = 8'h03; shamt = 3'd2;
        @(negedge clk);
        start = 1'b0;
        check_output("b2b_accepted", {31'd0, busy8}, 32'd1);
        check_output("result_held", {24'd0, result8}, 32'h01);
        lat = 1;
        wait_done(lat, nbusy);
        check_output("b2b_result", {24'd0, result8}, 32'h0C);
        check_output("b2b_latency", lat, 4);

        // Reset in the middle of a shift aborts it and clears the result.
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 8'h01; shamt = 3'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_output("abort_busy", {31'd0, busy8}, 32'd0);
        check_output("abort_done", {31'd0, done8}, 32'd0);
        check_output("abort_result", {24'd0, result8}, 32'd0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done8) pulses++;
        end
        check_output("abort_no_done", pulses, 0);
        apply_stimulus(2'b00, 8'h80, 3'd7, lat, nbusy);
        check_output("after_abort_result", {24'd0, result8}, 32'h01);

        // Narrow build: sign fill over the full width.
        apply_stimulus(2'b10, 8'h10, 3'd4, lat, nbusy);
        check_output("n5_sra_result", {27'd0, result5}, 32'h1F);
        check_output("n5_sra_result8", {24'd0, result8}, 32'h01);

        for (int r = 0; r < 20; r++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = 8'($urandom);
            rsh = 3'($urandom_range(0, 7));
            apply_stimulus(rop, ra, rsh, lat, nbusy);
            check_output($sformatf("rand%0d_result8", r), {24'd0, result8}, {24'd0, ref_shift(rop, ra, rsh, 8)});
            check_output($sformatf("rand%0d_result5", r), {27'd0, result5}, {24'd0, ref_shift(rop, ra, rsh, 5)});
            check_output($sformatf("rand%0d_latency", r), lat, rsh + 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
